vector_register_file: RTL and testbench
=======================================

# vector_register_file

Parametrised scalar and vector register file for the vector datapath. It holds NUM_SREG scalar registers (ELEM_W bits) and NUM_VREG vector registers (LANES×ELEM_W bits). It provides two independently typed registered read ports, one write port with per-lane write masking, same-cycle write-to-read bypass, and a pending-write scoreboard that flags read-after-write hazards to the decode stage. It sits between decode (read and claim side) and writeback (write side).

## Interface
- ELEM_W, 8, element / scalar register width in bits
- LANES, 24, elements per vector register (vector width = LANES×ELEM_W)
- NUM_SREG, 16, number of scalar registers
- NUM_VREG, 16, number of vector registers
- ADDR_W, 4, register address width; must satisfy 2^ADDR_W ≥ max(NUM_SREG, NUM_VREG)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read request
- rd1_addr, rd2_addr  in  ADDR_W  read addresses
- rd1_vec, rd2_vec  in  1  per-port type: 0 = scalar, 1 = vector
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_vec  in  1  write target type
- wr_mask  in  LANES  per-lane write enable; vector writes only
- wr_data  in  LANES×ELEM_W  write data; scalar writes use bits [ELEM_W-1:0]
- claim_en  in  1  mark a register as pending a future write
- claim_addr  in  ADDR_W  register to claim
- claim_vec  in  1  type of the claimed register
- r1s, r2s  out  ELEM_W  scalar read data
- r1v, r2v  out  LANES×ELEM_W  vector read data
- rd_valid  out  1  read data updated this cycle
- rd_hazard  out  1  read blocked by a pending register (combinational)
- rd_err  out  1  out-of-range read address

## Operation
- Reset (rst=1 at the clock edge):
  - All registers, all pending bits and all outputs clear to 0.
  - rd_valid, rd_hazard and rd_err are 0.
- Write: when wr_en=1 and the address is in range for wr_vec:
  - Scalar writes store wr_data[ELEM_W-1:0] and ignore wr_mask.
  - Vector writes update only lanes whose wr_mask bit is 1.
  - A write clears the pending bit of its target register.
  - Out-of-range writes are dropped silently.
- Read: when rd_en=1 and rd_hazard=0:
  - Each port loads its scalar output (rdX_vec=0) or its vector output (rdX_vec=1).
  - The output of the unselected type holds its previous value.
  - rd_valid pulses 1 for one cycle.
  - An out-of-range address on either port returns 0 on that port and sets rd_err for that cycle.
- Bypass: if a read port matches the same-cycle write (same address and type), the port returns the newly written value. For vector reads this merges wr_data lanes under wr_mask with the stored lanes.
- Scoreboard:
  - claim_en sets the pending bit for (claim_addr, claim_vec).
  - rd_hazard = rd_en & (pending(rd1) | pending(rd2)).
  - The check uses the pending bits as they stand before this edge.
  - A pending bit also being cleared by a same-cycle write does not raise the hazard; the bypass resolves it.
- When a read is blocked by rd_hazard: outputs hold, rd_valid=0, rd_err=0. Decode must re-present the read.
- Claim and write to the same register in the same cycle: the claim wins and the bit ends set.
- Claiming an out-of-range register is ignored.
- Scalar and vector address spaces are independent: scalar reg 3 and vector reg 3 are distinct.

## Timing
- Read latency: 1 cycle. Inputs are sampled at edge N; r*/rd_valid/rd_err are valid after edge N.
- Write-to-read latency: 0 (bypass) for a same-cycle read; otherwise the data is visible from the next read.
- Claim takes effect from the following cycle for hazard checks.
- rd_hazard is combinational from rd_en, the addresses and the pending state; it has no registered delay.
- Reset asserted mid-operation overrides any write, claim or read issued in that same cycle.

## Test plan
- Reset then read: after reset, read scalar reg 0 and vector reg 5 → r1s=0, r2v=0, rd_valid=1 one cycle later.
- Masked vector write: write vector reg 2 with all-0xAA and full mask, then with 0x55 data and mask=0x000001 → lane 0=0x55, lanes 1–23=0xAA.
- Bypass: in one cycle, write scalar reg 7 with 0x3C and read rd1 scalar reg 7 → r1s=0x3C after that edge.
- Hazard:
  - Claim vector reg 4, then read vector reg 4 → rd_hazard=1, rd_valid=0, outputs unchanged.
  - Write reg 4 with a same-cycle read → rd_hazard=0, bypassed data returned.
- Mixed types and range: with NUM_SREG=12, read rd1 scalar 13, rd2 vector 1 → r1s=0, rd_err=1, r2v=stored value.
- Claim/write collision and reset: claim and write scalar 9 in the same cycle → next read of 9 has hazard=1. Assert rst while a write is in progress → all registers and pending bits are 0.

Source files
------------

// File: rtl/vector_register_file_if.sv
// Decode/writeback-facing bundle for vector_register_file: read, write and claim
// request signals plus registered read results and the combinational hazard flag.
interface vector_register_file_if #(
    parameter int ELEM_W = 8,
    parameter int LANES  = 24,
    parameter int ADDR_W = 4
);
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd1_addr;
    logic [ADDR_W-1:0]         rd2_addr;
    logic                      rd1_vec;
    logic                      rd2_vec;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic                      wr_vec;
    logic [LANES-1:0]          wr_mask;
    logic [LANES*ELEM_W-1:0]   wr_data;
    logic                      claim_en;
    logic [ADDR_W-1:0]         claim_addr;
    logic                      claim_vec;
    logic [ELEM_W-1:0]         r1s;
    logic [ELEM_W-1:0]         r2s;
    logic [LANES*ELEM_W-1:0]   r1v;
    logic [LANES*ELEM_W-1:0]   r2v;
    logic                      rd_valid;
    logic                      rd_hazard;
    logic                      rd_err;

    modport master (
        output rd_en, rd1_addr, rd2_addr, rd1_vec, rd2_vec,
        output wr_en, wr_addr, wr_vec, wr_mask, wr_data,
        output claim_en, claim_addr, claim_vec,
        input  r1s, r2s, r1v, r2v, rd_valid, rd_hazard, rd_err
    );

    modport slave (
        input  rd_en, rd1_addr, rd2_addr, rd1_vec, rd2_vec,
        input  wr_en, wr_addr, wr_vec, wr_mask, wr_data,
        input  claim_en, claim_addr, claim_vec,
        output r1s, r2s, r1v, r2v, rd_valid, rd_hazard, rd_err
    );
endinterface

// File: rtl/vector_register_file.sv
// Scalar + vector register file with two typed registered read ports, a lane-masked
// write port, same-cycle write bypass and a pending-write scoreboard for decode.
module vector_register_file #(
    parameter int ELEM_W   = 8,
    parameter int LANES    = 24,
    parameter int NUM_SREG = 16,
    parameter int NUM_VREG = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_register_file_if.slave rf
);
    localparam int VEC_W = LANES * ELEM_W;

    logic [ELEM_W-1:0]   r_sreg [NUM_SREG];
    logic [VEC_W-1:0]    r_vreg [NUM_VREG];
    logic [NUM_SREG-1:0] r_spend;
    logic [NUM_VREG-1:0] r_vpend;
    logic [ELEM_W-1:0]   r_r1s;
    logic [ELEM_W-1:0]   r_r2s;
    logic [VEC_W-1:0]    r_r1v;
    logic [VEC_W-1:0]    r_r2v;
    logic                r_valid;
    logic                r_err;

    logic                w_wr_ok;
    logic                w_claim_ok;
    logic [VEC_W-1:0]    w_wr_old;
    logic [VEC_W-1:0]    w_wr_vmerge;
    logic [ADDR_W-1:0]   w_addr [2];
    logic                w_isvec [2];
    logic [1:0]          w_byp;
    logic [1:0]          w_blk;
    logic [1:0]          w_oor;
    logic [VEC_W-1:0]    w_rdata [2];
    logic                w_rd_go;

    function automatic logic in_range(input logic [ADDR_W-1:0] a, input logic v);
        return v ? (32'(a) < NUM_VREG) : (32'(a) < NUM_SREG);
    endfunction

    assign w_addr[0]  = rf.rd1_addr;
    assign w_addr[1]  = rf.rd2_addr;
    assign w_isvec[0] = rf.rd1_vec;
    assign w_isvec[1] = rf.rd2_vec;

    assign w_wr_ok    = rf.wr_en & in_range(rf.wr_addr, rf.wr_vec);
    assign w_claim_ok = rf.claim_en & in_range(rf.claim_addr, rf.claim_vec);

    // The merged vector serves both as the value committed and as the bypass result.
    always_comb begin
        w_wr_old    = '0;
        w_wr_vmerge = '0;
        if (w_wr_ok && rf.wr_vec) w_wr_old = r_vreg[rf.wr_addr];
        for (int unsigned l = 0; l < LANES; l++) begin
            w_wr_vmerge[l*ELEM_W +: ELEM_W] = rf.wr_mask[l] ? rf.wr_data[l*ELEM_W +: ELEM_W]
                                                            : w_wr_old[l*ELEM_W +: ELEM_W];
        end
    end

    // A pending bit cleared by this cycle's write is not a hazard; the bypass supplies the data.
    always_comb begin
        w_byp = '0;
        w_blk = '0;
        w_oor = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            w_byp[p]   = w_wr_ok && (rf.wr_addr == w_addr[p]) && (rf.wr_vec == w_isvec[p]);
            if (!in_range(w_addr[p], w_isvec[p])) begin
                w_oor[p] = 1'b1;
            end else if (w_isvec[p]) begin
                w_rdata[p] = w_byp[p] ? w_wr_vmerge : r_vreg[w_addr[p]];
                w_blk[p]   = r_vpend[w_addr[p]] & ~w_byp[p];
            end else begin
                w_rdata[p] = w_byp[p] ? VEC_W'(rf.wr_data[ELEM_W-1:0]) : VEC_W'(r_sreg[w_addr[p]]);
                w_blk[p]   = r_spend[w_addr[p]] & ~w_byp[p];
            end
        end
    end

    assign rf.rd_hazard = rf.rd_en & (|w_blk);
    assign w_rd_go      = rf.rd_en & ~rf.rd_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SREG; i++) r_sreg[i] <= '0;
            for (int unsigned i = 0; i < NUM_VREG; i++) r_vreg[i] <= '0;
            r_spend <= '0;
            r_vpend <= '0;
            r_r1s   <= '0;
            r_r2s   <= '0;
            r_r1v   <= '0;
            r_r2v   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                if (rf.wr_vec) begin
                    r_vreg[rf.wr_addr]  <= w_wr_vmerge;
                    r_vpend[rf.wr_addr] <= 1'b0;
                end else begin
                    r_sreg[rf.wr_addr]  <= rf.wr_data[ELEM_W-1:0];
                    r_spend[rf.wr_addr] <= 1'b0;
                end
            end
            // Issued after the write clear so a same-register claim leaves the bit set.
            if (w_claim_ok) begin
                if (rf.claim_vec) r_vpend[rf.claim_addr] <= 1'b1;
                else              r_spend[rf.claim_addr] <= 1'b1;
            end
            r_valid <= w_rd_go;
            r_err   <= w_rd_go & (|w_oor);
            if (w_rd_go) begin
                if (rf.rd1_vec) r_r1v <= w_rdata[0];
                else            r_r1s <= w_rdata[0][ELEM_W-1:0];
                if (rf.rd2_vec) r_r2v <= w_rdata[1];
                else            r_r2s <= w_rdata[1][ELEM_W-1:0];
            end
        end
    end

    assign rf.r1s      = r_r1s;
    assign rf.r2s      = r_r2s;
    assign rf.r1v      = r_r1v;
    assign rf.r2v      = r_r2v;
    assign rf.rd_valid = r_valid;
    assign rf.rd_err   = r_err;
endmodule

// File: tb/tb_vector_register_file.sv
// Randomised + directed bench for vector_register_file (NUM_SREG=12 to expose range errors),
// compared against a lane-array reference model.
module tb_vector_register_file;
    localparam int ELEM_W = 8;
    localparam int LANES  = 24;
    localparam int NSREG  = 12;
    localparam int NVREG  = 16;
    localparam int ADDR_W = 4;
    localparam int VEC_W  = LANES * ELEM_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_register_file_if #(.ELEM_W(ELEM_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    vector_register_file #(
        .ELEM_W(ELEM_W), .LANES(LANES), .NUM_SREG(NSREG), .NUM_VREG(NVREG), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [7:0] m_s [16];
    logic [7:0] m_v [16][LANES];
    bit         m_sp [16];
    bit         m_vp [16];
    logic [7:0]       e_r1s, e_r2s;
    logic [VEC_W-1:0] e_r1v, e_r2v;
    bit               e_valid, e_err, e_haz;

    task automatic check_eq(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit inr(input int a, input bit v);
        return v ? (a < NVREG) : (a < NSREG);
    endfunction

    function automatic logic [VEC_W-1:0] vpack(input int a);
        logic [VEC_W-1:0] r = '0;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = m_v[a][l];
        return r;
    endfunction

    function automatic bit pend_eff(input int a, input bit v);
        bit wclr;
        if (!inr(a, v)) return 1'b0;
        wclr = bus.wr_en && inr(int'(bus.wr_addr), bus.wr_vec) && int'(bus.wr_addr) == a && bus.wr_vec == v;
        return (v ? m_vp[a] : m_sp[a]) && !wclr;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_s[i] = '0; m_sp[i] = 0; m_vp[i] = 0;
            for (int l = 0; l < LANES; l++) m_v[i][l] = '0;
        end
        e_r1s = '0; e_r2s = '0; e_r1v = '0; e_r2v = '0; e_valid = 0; e_err = 0;
    endtask

    // One clock edge of the reference: write applied first, so reads naturally see bypassed data.
    task automatic model_step();
        int wa, a1, a2, ca;
        logic [VEC_W-1:0] v1, v2;
        wa = int'(bus.wr_addr); a1 = int'(bus.rd1_addr); a2 = int'(bus.rd2_addr); ca = int'(bus.claim_addr);
        if (rst) begin
            model_reset();
            return;
        end
        if (bus.wr_en && inr(wa, bus.wr_vec)) begin
            if (bus.wr_vec) begin
                for (int l = 0; l < LANES; l++)
                    if (bus.wr_mask[l]) m_v[wa][l] = bus.wr_data[l*8 +: 8];
                m_vp[wa] = 0;
            end else begin
                m_s[wa]  = bus.wr_data[7:0];
                m_sp[wa] = 0;
            end
        end
        if (bus.rd_en && !e_haz) begin
            e_valid = 1;
            e_err   = !inr(a1, bus.rd1_vec) || !inr(a2, bus.rd2_vec);
            v1 = !inr(a1, bus.rd1_vec) ? '0 : (bus.rd1_vec ? vpack(a1) : VEC_W'(m_s[a1]));
            v2 = !inr(a2, bus.rd2_vec) ? '0 : (bus.rd2_vec ? vpack(a2) : VEC_W'(m_s[a2]));
            if (bus.rd1_vec) e_r1v = v1; else e_r1s = v1[7:0];
            if (bus.rd2_vec) e_r2v = v2; else e_r2s = v2[7:0];
        end else begin
            e_valid = 0;
            e_err   = 0;
        end
        if (bus.claim_en && inr(ca, bus.claim_vec)) begin
            if (bus.claim_vec) m_vp[ca] = 1; else m_sp[ca] = 1;
        end
    endtask

    task automatic idle();
        rst = 0;
        bus.rd_en = 0; bus.rd1_addr = '0; bus.rd2_addr = '0; bus.rd1_vec = 0; bus.rd2_vec = 0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_vec = 0; bus.wr_mask = '0; bus.wr_data = '0;
        bus.claim_en = 0; bus.claim_addr = '0; bus.claim_vec = 0;
    endtask

    task automatic step(input string tag);
        #1;
        e_haz = bus.rd_en && (pend_eff(int'(bus.rd1_addr), bus.rd1_vec) || pend_eff(int'(bus.rd2_addr), bus.rd2_vec));
        if (!rst) check_eq({tag, ".hazard"}, VEC_W'(bus.rd_hazard), VEC_W'(e_haz));
        model_step();
        @(posedge clk);
        #1;
        check_eq({tag, ".valid"}, VEC_W'(bus.rd_valid), VEC_W'(e_valid));
        check_eq({tag, ".err"},   VEC_W'(bus.rd_err),   VEC_W'(e_err));
        check_eq({tag, ".r1s"},   VEC_W'(bus.r1s),      VEC_W'(e_r1s));
        check_eq({tag, ".r2s"},   VEC_W'(bus.r2s),      VEC_W'(e_r2s));
        check_eq({tag, ".r1v"},   bus.r1v,              e_r1v);
        check_eq({tag, ".r2v"},   bus.r2v,              e_r2v);
        idle();
    endtask

    function automatic logic [VEC_W-1:0] fill(input logic [7:0] b);
        logic [VEC_W-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = b;
        return r;
    endfunction

    initial begin
        logic [VEC_W-1:0] rnd;
        model_reset();
        e_haz = 0;
        idle();
        rst = 1; step("reset");

        // reset then read
        bus.rd_en = 1; bus.rd1_addr = 4'd0; bus.rd2_addr = 4'd5; bus.rd2_vec = 1; step("rd_after_rst");

        // masked vector write
        bus.wr_en = 1; bus.wr_vec = 1; bus.wr_addr = 4'd2; bus.wr_mask = '1; bus.wr_data = fill(8'hAA); step("vw_full");
        bus.wr_en = 1; bus.wr_vec = 1; bus.wr_addr = 4'd2; bus.wr_mask = 24'h000001; bus.wr_data = fill(8'h55); step("vw_mask");
        bus.rd_en = 1; bus.rd1_vec = 1; bus.rd1_addr = 4'd2; bus.rd2_vec = 1; bus.rd2_addr = 4'd2; step("vr_mask");
        check_eq("lane0", VEC_W'(bus.r1v[7:0]), VEC_W'(8'h55));
        check_eq("lane23", VEC_W'(bus.r1v[VEC_W-1 -: 8]), VEC_W'(8'hAA));

        // scalar bypass
        bus.wr_en = 1; bus.wr_addr = 4'd7; bus.wr_data = VEC_W'(8'h3C);
        bus.rd_en = 1; bus.rd1_addr = 4'd7; step("s_bypass");
        check_eq("bypass_r1s", VEC_W'(bus.r1s), VEC_W'(8'h3C));

        // hazard on claimed vector 4, then resolving write with bypass
        bus.claim_en = 1; bus.claim_vec = 1; bus.claim_addr = 4'd4; step("claim_v4");
        bus.rd_en = 1; bus.rd1_vec = 1; bus.rd1_addr = 4'd4; step("haz_v4");
        bus.wr_en = 1; bus.wr_vec = 1; bus.wr_addr = 4'd4; bus.wr_mask = 24'h0F0F0F; bus.wr_data = fill(8'h96);
        bus.rd_en = 1; bus.rd1_vec = 1; bus.rd1_addr = 4'd4; step("byp_v4");

        // mixed types and out-of-range scalar
        bus.wr_en = 1; bus.wr_vec = 1; bus.wr_addr = 4'd1; bus.wr_mask = '1; bus.wr_data = fill(8'h21); step("vw1");
        bus.rd_en = 1; bus.rd1_addr = 4'd13; bus.rd2_vec = 1; bus.rd2_addr = 4'd1; step("oor_s13");
        bus.wr_en = 1; bus.wr_addr = 4'd12; bus.wr_data = VEC_W'(8'hEE); bus.claim_en = 1; bus.claim_addr = 4'd14; step("oor_w");

        // claim/write collision on scalar 9
        bus.claim_en = 1; bus.claim_addr = 4'd9; bus.wr_en = 1; bus.wr_addr = 4'd9; bus.wr_data = VEC_W'(8'h99); step("coll_s9");
        bus.rd_en = 1; bus.rd2_addr = 4'd9; step("haz_s9");

        // reset during write/claim
        rst = 1; bus.wr_en = 1; bus.wr_vec = 1; bus.wr_addr = 4'd1; bus.wr_mask = '1; bus.wr_data = fill(8'h77);
        bus.claim_en = 1; bus.claim_vec = 1; bus.claim_addr = 4'd3; step("rst_mid");
        bus.rd_en = 1; bus.rd1_vec = 1; bus.rd1_addr = 4'd1; bus.rd2_addr = 4'd9; step("after_rst");

        for (int n = 0; n < 600; n++) begin
            for (int w = 0; w < VEC_W / 32; w++) rnd[w*32 +: 32] = $urandom;
            rst          = ($urandom_range(0, 49) == 0);
            bus.rd_en    = ($urandom_range(0, 9) < 7);
            bus.rd1_addr = ADDR_W'($urandom_range(0, 15));
            bus.rd2_addr = ADDR_W'($urandom_range(0, 15));
            bus.rd1_vec  = 1'($urandom);
            bus.rd2_vec  = 1'($urandom);
            bus.wr_en    = 1'($urandom);
            bus.wr_addr  = ($urandom_range(0, 3) == 0) ? bus.rd1_addr : ADDR_W'($urandom_range(0, 15));
            bus.wr_vec   = 1'($urandom);
            bus.wr_mask  = LANES'($urandom);
            bus.wr_data  = rnd;
            bus.claim_en = ($urandom_range(0, 4) == 0);
            bus.claim_addr = ADDR_W'($urandom_range(0, 15));
            bus.claim_vec  = 1'($urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
